mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory between the IF stage (instruction fetch) and the MEM stage
//  (load/store) of the 5-stage pipeline. Runs a request/grant/complete handshake with each requester.
//  Issues one access at a time to the memory and exports per-requester stall signals to hazard/PC logic.
//  Data port has priority, except that a starvation limit guarantees fetch progress.
// PARAMETERS
//  ADDR_W      32  address width, all ports
//  DATA_W      32  data width, all ports
//  STARVE_MAX  4   consecutive D grants with fetch pending before fetch is forced to win; legal range >=1
// PORTS
//  clk_i        in   1       clock, rising edge
//  rst_i        in   1       synchronous active-low reset
//  if_req_i     in   1       fetch request; held until if_rvalid_o
//  if_addr_i    in   ADDR_W  fetch address
//  if_gnt_o     out  1       1-cycle pulse: fetch accepted, address captured
//  if_rvalid_o  out  1       1-cycle pulse: if_rdata_o valid
//  if_rdata_o   out  DATA_W  fetched instruction, registered
//  if_stall_o   out  1       if_req_i & ~if_rvalid_o (combinational)
//  d_req_i      in   1       data request; held until d_rvalid_o
//  d_we_i       in   1       1 = store, 0 = load
//  d_addr_i     in   ADDR_W  data address
//  d_wdata_i    in   DATA_W  store data
//  d_gnt_o      out  1       1-cycle pulse: data access accepted
//  d_rvalid_o   out  1       1-cycle pulse: load data valid / store done
//  d_rdata_o    out  DATA_W  load data, registered; unchanged on store completion
//  d_stall_o    out  1       d_req_i & ~d_rvalid_o (combinational)
//  mem_req_o    out  1       held high from issue until mem_ready_i sampled high
//  mem_we_o     out  1       write enable, stable while mem_req_o
//  mem_addr_o   out  ADDR_W  registered address, stable while mem_req_o
//  mem_wdata_o  out  DATA_W  registered store data
//  mem_rdata_i  in   DATA_W  read data, valid with mem_ready_i
//  mem_ready_i  in   1       access complete, any latency >=0 cycles after mem_req_o rises
//  perf_conf_o  out  32      conflict-cycle count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst_i==0 at a clock edge): state IDLE; starve_cnt 0; every output 0, including rdata
//    registers and perf_conf_o. Any in-flight access is abandoned and mem_req_o is low after that edge.
//    No rvalid is produced for the abandoned access.
//  - FSM states: IDLE, BUSY_I, BUSY_D.
//  - IDLE, no request: stay IDLE.
//  - IDLE, request present: arbitrate.
//    Pick I if if_req_i & (~d_req_i | starve_cnt==STARVE_MAX); otherwise pick D.
//    At the edge: capture addr, we and wdata into the mem_* registers, set mem_req_o=1, and pulse the
//    winner's gnt_o in the next cycle. State moves to BUSY_I or BUSY_D.
//    If I is chosen, mem_we_o=0 and mem_wdata_o holds its old value.
//  - BUSY_x with mem_ready_i=1 at an edge: capture mem_rdata_i into x_rdata_o (loads and fetches only).
//    Pulse x_rvalid_o for 1 cycle, drop mem_req_o, return to IDLE.
//  - BUSY_x with mem_ready_i=0: hold state and all mem_* outputs.
//  - mem_ready_i in IDLE is ignored.
//  - Latency: request seen in cycle 0 -> gnt_o and mem_req_o in cycle 1.
//    mem_ready_i in cycle k>=1 -> rvalid_o in cycle k+1. Re-arbitration happens in cycle k+1 (IDLE).
//  - starve_cnt:
//    +1 (saturating at STARVE_MAX) on each D grant made while if_req_i=1.
//    Cleared on an I grant, or in any IDLE cycle with if_req_i=0.
//  - A requester dropping req after gnt does not cancel the access; rvalid still pulses.
//  - Both requests arriving in the same cycle: D wins unless the starvation rule applies.
// CONFIGURATION
//  - ARB_PERF_CNT_EN defined:
//    perf_conf_o counts cycles with if_req_i & d_req_i & state==IDLE, wrapping at 2^32.
//    Cleared by reset.
//  - ARB_PERF_CNT_EN undefined: perf_conf_o tied to 0 and no counter flops are generated.
//    All other behaviour is identical.
// STRUCTURE
//  - Package arb_pkg holds:
//    state enum {IDLE, BUSY_I, BUSY_D}; owner enum {OWN_I, OWN_D}; localparam STARVE_W = $clog2(STARVE_MAX+1).
//  - Sub-module arb_prio_select: starve_cnt register plus the winner-select logic.
//    Inputs: if_req, d_req, grant event. Output: winner.
//  - FSM and the mem_* registers live in the top module.
// TESTING
//  1. Fetch alone, mem_ready_i 2 cycles after mem_req_o, mem_rdata_i=0x00500093.
//     -> if_gnt_o in cycle 1; if_rvalid_o and if_rdata_o=0x00500093 in cycle 4.
//  2. if_req_i and d_req_i (load, addr 0x10) raised in the same cycle.
//     -> D is granted first; mem_addr_o=0x10; fetch is granted after d_rvalid_o.
//  3. d_req_i held continuously, if_req_i held, STARVE_MAX=4.
//     -> grant sequence D,D,D,D,I,D...; starve_cnt returns to 0 after the I grant.
//  4. Store: d_we_i=1, addr 0x20, wdata 0xDEADBEEF.
//     -> mem_we_o=1 and mem_wdata_o=0xDEADBEEF while mem_req_o; d_rvalid_o pulses; d_rdata_o unchanged.
//  5. rst_i driven low during BUSY_D.
//     -> after the edge: mem_req_o=0, state IDLE, no d_rvalid_o pulse; fresh arbitration after rst_i=1.
//  6. With ARB_PERF_CNT_EN: 3 cycles of simultaneous requests in IDLE -> perf_conf_o=3.
//     Without the macro -> perf_conf_o=0.

Source files
------------

// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// Module  : arb_pkg
// Purpose : Shared types and helpers for the mem_port_arbiter slice.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int STARVE_MAX_DEF = 4;
  localparam int STARVE_W       = $clog2(STARVE_MAX_DEF + 1);

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/arb_prio_select.sv
// ---------------------------------------------------------------------------
// Module  : arb_prio_select
// Purpose : Fetch-starvation counter and I/D winner selection.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module arb_prio_select
  import arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int CNT_W      = STARVE_W
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   if_req_i,
  input  logic   d_req_i,
  input  logic   idle_i,
  input  logic   gnt_ev_i,
  output owner_e winner_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  owner_e           w_winner;

  // Data wins by default; fetch wins once it has been passed over STARVE_MAX times.
  assign w_winner = (if_req_i && (!d_req_i || (starve_cnt_q == CNT_MAX))) ? OWN_I : OWN_D;
  assign winner_o = w_winner;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (gnt_ev_i && (w_winner == OWN_I)) begin
      starve_cnt_d = '0;
    end else if (gnt_ev_i && if_req_i) begin
      starve_cnt_d = (starve_cnt_q == CNT_MAX) ? starve_cnt_q : starve_cnt_q + CNT_W'(1);
    end else if (idle_i && !if_req_i) begin
      starve_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// Module  : mem_port_arbiter
// Purpose : Shares one single-port memory between fetch (I) and load/store (D).
//           Optional conflict counter enabled by macro ARB_PERF_CNT_EN.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_stall_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  output logic [31:0]       perf_conf_o
);

  state_e              state_q, state_d;
  logic                if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
  logic                if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic                w_idle;
  logic                w_gnt_ev;
  owner_e              w_winner;

  assign w_idle   = (state_q == IDLE);
  assign w_gnt_ev = w_idle && (if_req_i || d_req_i);

  arb_prio_select #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (cnt_width(STARVE_MAX))
  ) u_prio (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .if_req_i (if_req_i),
    .d_req_i  (d_req_i),
    .idle_i   (w_idle),
    .gnt_ev_i (w_gnt_ev),
    .winner_o (w_winner)
  );

  always_comb begin
    state_d     = state_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (w_gnt_ev) begin
          mem_req_d = 1'b1;
          if (w_winner == OWN_I) begin
            state_d    = BUSY_I;
            mem_addr_d = if_addr_i;
            mem_we_d   = 1'b0;
            if_gnt_d   = 1'b1;
          end else begin
            state_d     = BUSY_D;
            mem_addr_d  = d_addr_i;
            mem_we_d    = d_we_i;
            mem_wdata_d = d_wdata_i;
            d_gnt_d     = 1'b1;
          end
        end
      end
      BUSY_I: begin
        if (mem_ready_i) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          if_rvalid_d = 1'b1;
          if_rdata_d  = mem_rdata_i;
        end
      end
      BUSY_D: begin
        if (mem_ready_i) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          d_rvalid_d = 1'b1;
          // Stores complete without disturbing the last load result.
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      perf_q <= '0;
    end else if (w_idle && if_req_i && d_req_i) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_conf_o = perf_q;
`else
  assign perf_conf_o = '0;
`endif

  assign if_gnt_o    = if_gnt_q;
  assign d_gnt_o     = d_gnt_q;
  assign if_rvalid_o = if_rvalid_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_stall_o  = if_req_i & ~if_rvalid_q;
  assign d_stall_o   = d_req_i & ~d_rvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// Module  : tb_mem_port_arbiter
// Purpose : Directed and randomized checks of mem_port_arbiter against a
//           transaction-level model (honours ARB_PERF_CNT_EN).
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst_n, if_req, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_gnt_o, if_rvalid_o, if_stall_o, d_gnt_o, d_rvalid_o, d_stall_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o, perf_conf_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o),
    .if_rdata_o(if_rdata_o), .if_stall_o(if_stall_o),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o), .d_stall_o(d_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready), .perf_conf_o(perf_conf_o)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one access outstanding, owned by I or D.
  bit          m_busy, m_own_d, m_we;
  int          m_starve;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata, m_perf;
  bit          e_if_gnt, e_d_gnt, e_if_rv, e_d_rv;

  always @(posedge clk) begin : p_model
    bit          p_rst, p_ir, p_dr, p_dwe, p_rdy, pick_i;
    logic [31:0] p_ia, p_da, p_dwd, p_rd;
    logic [31:0] exp_perf;
    p_rst = rst_n;  p_ir = if_req;  p_dr = d_req;  p_dwe = d_we;  p_rdy = mem_ready;
    p_ia  = if_addr; p_da = d_addr; p_dwd = d_wdata; p_rd = mem_rdata;
    e_if_gnt = 0; e_d_gnt = 0; e_if_rv = 0; e_d_rv = 0;
    if (!p_rst) begin
      m_busy = 0; m_own_d = 0; m_we = 0; m_starve = 0;
      m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_d_rdata = '0; m_perf = '0;
    end else if (!m_busy) begin
      if (p_ir && p_dr) m_perf = m_perf + 32'd1;
      if (p_ir || p_dr) begin
        pick_i  = p_ir && (!p_dr || m_starve >= SMAX);
        m_busy  = 1;
        m_own_d = !pick_i;
        if (pick_i) begin
          m_addr = p_ia; m_we = 0; e_if_gnt = 1;
        end else begin
          m_addr = p_da; m_we = p_dwe; m_wdata = p_dwd; e_d_gnt = 1;
        end
        if (pick_i || !p_ir) m_starve = 0;
        else m_starve = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
      end else begin
        m_starve = 0;
      end
    end else if (p_rdy) begin
      m_busy = 0;
      if (!m_own_d) begin
        e_if_rv = 1; m_if_rdata = p_rd;
      end else begin
        e_d_rv = 1;
        if (!m_we) m_d_rdata = p_rd;
      end
    end
`ifdef ARB_PERF_CNT_EN
    exp_perf = m_perf;
`else
    exp_perf = 32'd0;
`endif
    #1;
    chk1("m_if_gnt", if_gnt_o, e_if_gnt);
    chk1("m_d_gnt", d_gnt_o, e_d_gnt);
    chk1("m_if_rvalid", if_rvalid_o, e_if_rv);
    chk1("m_d_rvalid", d_rvalid_o, e_d_rv);
    chk1("m_mem_req", mem_req_o, m_busy);
    chk32("m_if_rdata", if_rdata_o, m_if_rdata);
    chk32("m_d_rdata", d_rdata_o, m_d_rdata);
    chk32("m_perf", perf_conf_o, exp_perf);
    chk1("m_if_stall", if_stall_o, if_req & ~e_if_rv);
    chk1("m_d_stall", d_stall_o, d_req & ~e_d_rv);
    if (m_busy) begin
      chk32("m_mem_addr", mem_addr_o, m_addr);
      chk1("m_mem_we", mem_we_o, m_we);
      chk32("m_mem_wdata", mem_wdata_o, m_wdata);
    end
  end

  initial begin : p_stim
    logic [9:0] seq;
    int         ng, ip, dp, rp;
    bit         i_wait, d_wait;
    rst_n = 0; if_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk1("rst_mem_req", mem_req_o, 1'b0);
    chk1("rst_if_gnt", if_gnt_o, 1'b0);
    chk32("rst_if_rdata", if_rdata_o, 32'h0);
    chk32("rst_d_rdata", d_rdata_o, 32'h0);
    chk32("rst_mem_addr", mem_addr_o, 32'h0);
    chk32("rst_perf", perf_conf_o, 32'h0);
    rst_n = 1;
    @(negedge clk);

    // Fetch alone, memory answers two cycles after the request rises.
    if_req = 1; if_addr = 32'h100;
    @(negedge clk);
    chk1("t1_if_gnt", if_gnt_o, 1'b1);
    chk1("t1_mem_req", mem_req_o, 1'b1);
    chk32("t1_mem_addr", mem_addr_o, 32'h100);
    chk1("t1_if_stall", if_stall_o, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk1("t1_no_rvalid", if_rvalid_o, 1'b0);
    mem_ready = 1; mem_rdata = 32'h00500093;
    @(negedge clk);
    chk1("t1_if_rvalid", if_rvalid_o, 1'b1);
    chk32("t1_if_rdata", if_rdata_o, 32'h00500093);
    chk1("t1_if_stall_rv", if_stall_o, 1'b0);
    if_req = 0; mem_ready = 0;

    // Simultaneous requests: data first, then fetch.
    @(negedge clk);
    if_req = 1; if_addr = 32'h200; d_req = 1; d_we = 0; d_addr = 32'h10;
    @(negedge clk);
    chk1("t2_d_gnt", d_gnt_o, 1'b1);
    chk1("t2_if_gnt", if_gnt_o, 1'b0);
    chk32("t2_mem_addr", mem_addr_o, 32'h10);
    mem_ready = 1; mem_rdata = 32'h12345678;
    @(negedge clk);
    chk1("t2_d_rvalid", d_rvalid_o, 1'b1);
    chk32("t2_d_rdata", d_rdata_o, 32'h12345678);
    d_req = 0; mem_ready = 0;
    @(negedge clk);
    chk1("t2_if_gnt2", if_gnt_o, 1'b1);
    chk32("t2_mem_addr2", mem_addr_o, 32'h200);
    mem_ready = 1; mem_rdata = 32'h00000013;
    @(negedge clk);
    chk1("t2_if_rvalid", if_rvalid_o, 1'b1);
    if_req = 0; mem_ready = 0;

    // Both held, zero-latency memory: starvation pattern.
    @(negedge clk);
    if_req = 1; if_addr = 32'h300; d_req = 1; d_we = 0; d_addr = 32'h40;
    mem_ready = 1; mem_rdata = 32'h00001111;
    seq = '0; ng = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (d_gnt_o) begin seq = {seq[8:0], 1'b1}; ng++; end
      else if (if_gnt_o) begin seq = {seq[8:0], 1'b0}; ng++; end
    end
    chk32("t3_grant_count", 32'(ng), 32'd10);
    chk32("t3_grant_seq", {22'd0, seq}, {22'd0, 10'b1111011110});
    if_req = 0; d_req = 0; mem_ready = 0;

    // Store leaves the load result untouched.
    @(negedge clk);
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk1("t4_d_gnt", d_gnt_o, 1'b1);
    chk1("t4_mem_we", mem_we_o, 1'b1);
    chk32("t4_mem_wdata", mem_wdata_o, 32'hDEADBEEF);
    chk32("t4_mem_addr", mem_addr_o, 32'h20);
    @(negedge clk);
    chk1("t4_mem_req_hold", mem_req_o, 1'b1);
    mem_ready = 1;
    @(negedge clk);
    chk1("t4_d_rvalid", d_rvalid_o, 1'b1);
    chk32("t4_d_rdata", d_rdata_o, 32'h00001111);
    chk1("t4_mem_req_low", mem_req_o, 1'b0);
    d_req = 0; d_we = 0; mem_ready = 0;

    // Reset while a data access is in flight.
    @(negedge clk);
    d_req = 1; d_addr = 32'h30;
    @(negedge clk);
    chk1("t5_d_gnt", d_gnt_o, 1'b1);
    @(negedge clk);
    rst_n = 0; d_req = 0; mem_ready = 1;
    @(negedge clk);
    chk1("t5_mem_req", mem_req_o, 1'b0);
    chk1("t5_no_rvalid", d_rvalid_o, 1'b0);
    chk32("t5_d_rdata", d_rdata_o, 32'h0);
    rst_n = 1; mem_ready = 0; d_req = 1; d_addr = 32'h34;
    @(negedge clk);
    chk1("t5_regrant", d_gnt_o, 1'b1);
    chk32("t5_mem_addr", mem_addr_o, 32'h34);
    mem_ready = 1;
    @(negedge clk);
    chk1("t5_d_rvalid", d_rvalid_o, 1'b1);
    d_req = 0; mem_ready = 0;

    // Three IDLE cycles with both requests present.
    @(negedge clk);
    if_req = 1; d_req = 1; if_addr = 32'h500; d_addr = 32'h50; mem_ready = 1;
    repeat (5) @(negedge clk);
`ifdef ARB_PERF_CNT_EN
    chk32("t6_perf", perf_conf_o, 32'd3);
`else
    chk32("t6_perf", perf_conf_o, 32'd0);
`endif
    if_req = 0; d_req = 0;
    @(negedge clk);
    mem_ready = 0;
    @(negedge clk);

    // Randomized traffic with requesters driven by the model's handshake.
    i_wait = 0; d_wait = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      case ((c / 500) % 3)
        0:       begin ip = 50;  dp = 50;  rp = 50; end
        1:       begin ip = 100; dp = 100; rp = 70; end
        default: begin ip = 30;  dp = 90;  rp = 30; end
      endcase
      if (c > 20 && $urandom_range(0, 199) == 0) begin
        rst_n = 0; i_wait = 0; d_wait = 0; if_req = 0; d_req = 0;
      end else begin
        rst_n = 1;
        if (i_wait && e_if_rv) i_wait = 0;
        if (d_wait && e_d_rv) d_wait = 0;
        if (i_wait) begin
          if (if_req && m_busy && !m_own_d && $urandom_range(0, 7) == 0) if_req = 0;
        end else if ($urandom_range(0, 99) < ip) begin
          if_req = 1; if_addr = $urandom; i_wait = 1;
        end else begin
          if_req = 0;
        end
        if (d_wait) begin
          if (d_req && m_busy && m_own_d && $urandom_range(0, 7) == 0) d_req = 0;
        end else if ($urandom_range(0, 99) < dp) begin
          d_req = 1; d_we = 1'($urandom_range(0, 1));
          d_addr = $urandom; d_wdata = $urandom; d_wait = 1;
        end else begin
          d_req = 0;
        end
      end
      mem_ready = ($urandom_range(0, 99) < rp);
      mem_rdata = $urandom;
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
